// File: rtl/flag_gen.sv
// flag_gen: two-stage subtract pipeline producing a - b with zero (z),
// signed-overflow (v) and negative (n) flags, plus the two compare-select
// bits carried alongside the operation.
//
// Optional feature: define FLAG_GEN_OVF_CNT_EN to build an 8-bit saturating
// counter of valid overflowing results on ovf_count. When the macro is
// undefined, ovf_count is tied to zero and no counter logic exists.
//
// Pipeline control: flush beats stall, stall beats normal flow. A flush
// clears only the valid bits; data registers keep their contents. Stage 2
// data (result, flags, select bits) loads only with a valid operation, so
// those outputs hold their last values through bubbles.
module flag_gen #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ALUOp_three_in,
  input  logic             ALUOp_one_in,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic             z,
  output logic             v,
  output logic             n,
  output logic [WIDTH-1:0] result,
  output logic             ALUOp_three,
  output logic             ALUOp_one,
  output logic [7:0]       ovf_count
);

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_op3_q, s1_op3_d;
  logic             s1_op1_q, s1_op1_d;

  // Stage 2 state (drives the outputs directly)
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_res_q, s2_res_d;
  logic             s2_z_q, s2_z_d;
  logic             s2_v_q, s2_v_d;
  logic             s2_n_q, s2_n_d;
  logic             s2_op3_q, s2_op3_d;
  logic             s2_op1_q, s2_op1_d;

  // Stage 2 arithmetic on the stage 1 operands
  logic [WIDTH-1:0] diff_s;
  logic             zero_s;
  logic             ovf_s;
  logic             load2_s;

  // Difference and flags computed from the registered operands
  always_comb begin
    diff_s  = s1_a_q - s1_b_q;
    zero_s  = (diff_s == {WIDTH{1'b0}});
    ovf_s   = (s1_a_q[WIDTH-1] ^ s1_b_q[WIDTH-1]) & (diff_s[WIDTH-1] ^ s1_a_q[WIDTH-1]);
    load2_s = ~flush & ~stall & s1_valid_q;
  end

  // Stage 1 next state: flush clears valid, stall holds, otherwise accept
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op3_d   = s1_op3_q;
    s1_op1_d   = s1_op1_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (stall) begin
      s1_valid_d = s1_valid_q;
    end else begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d   = a;
        s1_b_d   = b;
        s1_op3_d = ALUOp_three_in;
        s1_op1_d = ALUOp_one_in;
      end else begin
        s1_a_d   = s1_a_q;
      end
    end
  end

  // Stage 2 next state: data loads only with a valid stage 1 operation
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_z_d     = s2_z_q;
    s2_v_d     = s2_v_q;
    s2_n_d     = s2_n_q;
    s2_op3_d   = s2_op3_q;
    s2_op1_d   = s2_op1_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (stall) begin
      s2_valid_d = s2_valid_q;
    end else begin
      s2_valid_d = s1_valid_q;
      if (load2_s) begin
        s2_res_d = diff_s;
        s2_z_d   = zero_s;
        s2_v_d   = ovf_s;
        s2_n_d   = diff_s[WIDTH-1];
        s2_op3_d = s1_op3_q;
        s2_op1_d = s1_op1_q;
      end else begin
        s2_res_d = s2_res_q;
      end
    end
  end

  // Pipeline registers with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= {WIDTH{1'b0}};
      s1_b_q     <= {WIDTH{1'b0}};
      s1_op3_q   <= 1'b0;
      s1_op1_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= {WIDTH{1'b0}};
      s2_z_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s2_n_q     <= 1'b0;
      s2_op3_q   <= 1'b0;
      s2_op1_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op3_q   <= s1_op3_d;
      s1_op1_q   <= s1_op1_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_z_q     <= s2_z_d;
      s2_v_q     <= s2_v_d;
      s2_n_q     <= s2_n_d;
      s2_op3_q   <= s2_op3_d;
      s2_op1_q   <= s2_op1_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign result      = s2_res_q;
  assign z           = s2_z_q;
  assign v           = s2_v_q;
  assign n           = s2_n_q;
  assign ALUOp_three = s2_op3_q;
  assign ALUOp_one   = s2_op1_q;

`ifdef FLAG_GEN_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  // Saturating count of overflowing operations entering stage 2
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (load2_s && ovf_s && (ovf_cnt_q != 8'd255)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  // Overflow counter register; only reset clears it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_cnt_q <= 8'd0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_count = ovf_cnt_q;
`else
  assign ovf_count = 8'd0;
`endif

endmodule

// File: doc/flag_gen.md
FLAG_GEN -- requirements
Module: flag_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and result width (minimum 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, the operation presented this cycle is valid.
REQ-005 SHALL have port a, input, WIDTH, the minuend.
REQ-006 SHALL have port b, input, WIDTH, the subtrahend.
REQ-007 SHALL have ports ALUOp_three_in and ALUOp_one_in, input, 1 each, the compare-select bits carried with the operation.
REQ-008 SHALL have port stall, input, 1, hold both pipeline stages.
REQ-009 SHALL have port flush, input, 1, kill all in-flight operations.
REQ-010 SHALL have port out_valid, output, 1, the flags and result are valid.
REQ-011 SHALL have ports z, v and n, output, 1 each: zero, signed overflow and negative flags.
REQ-012 SHALL have port result, output, WIDTH, the difference a - b.
REQ-013 SHALL have ports ALUOp_three and ALUOp_one, output, 1 each, the select bits aligned with the flags.
REQ-014 SHALL have port ovf_count, output, 8, the saturating overflow count (see Configuration).

Function
REQ-015 SHALL be a 2-stage pipeline: stage 1 registers a, b, the select bits and in_valid; stage 2 registers the difference, flags, select bits and valid.
REQ-016 SHALL give latency 2: an accepted operation in cycle N appears with out_valid=1 after edge N+2.
REQ-017 SHALL accept one operation per cycle when stall=0 (throughput 1).
REQ-018 SHALL compute result = a - b modulo 2^WIDTH.
REQ-019 SHALL set z = 1 iff result is 0.
REQ-020 SHALL set n = result[WIDTH-1].
REQ-021 SHALL set v = 1 iff a[WIDTH-1] differs from b[WIDTH-1] and result[WIDTH-1] differs from a[WIDTH-1].
REQ-022 SHALL, while stall=1, hold every stage register (including valid bits) and ignore inputs.
REQ-023 SHALL, while flush=1, clear both stage valid bits at the next edge.
REQ-024 SHALL give flush priority over stall and over a simultaneous in_valid; the flushed input is dropped.
REQ-025 SHALL leave data registers unchanged on flush; only the valid bits clear.
REQ-026 SHALL let stage 2 load a bubble (out_valid=0) when stage 1 holds no valid operation and stall=0.
REQ-027 SHALL hold the z, v, n and result outputs at their last loaded values while out_valid=0.

Reset
REQ-028 SHALL, when reset_n=0, immediately clear both valid bits, z, v, n, result, ALUOp_three, ALUOp_one and ovf_count to 0, without waiting for a clock edge.
REQ-029 SHALL discard all in-flight operations if reset is asserted mid-operation; the first valid output after deassertion comes 2 accepted cycles later.
REQ-030 SHALL deassert reset without glitching any output; outputs stay 0 until the first load.

Configuration
REQ-031 SHALL, with macro FLAG_GEN_OVF_CNT_EN defined, increment ovf_count by 1 each cycle stage 2 loads a valid operation with v=1.
REQ-032 SHALL saturate ovf_count at 255; a flush does not clear it, only reset does.
REQ-033 SHALL, with FLAG_GEN_OVF_CNT_EN undefined, drive ovf_count constant 0 and build no counter logic.

Verification
REQ-034 SHALL cover: a=5, b=5, in_valid=1 in cycle 0 -> after edge 2, out_valid=1, z=1, n=0, v=0, result=0.
REQ-035 SHALL cover: a=0x80000000, b=1 -> result=0x7FFFFFFF, v=1, n=0, z=0; with the macro defined, ovf_count=1.
REQ-036 SHALL cover: a=3, b=7 accepted, then stall=1 for 3 cycles -> out_valid and flags are frozen; result 0xFFFFFFFC, n=1 appears 2 unstalled edges after acceptance.
REQ-037 SHALL cover: flush=1 together with stall=1 and in_valid=1 while two operations are in flight -> out_valid=0 for the next 2 cycles, and the data outputs are unchanged.
REQ-038 SHALL cover: reset_n pulsed low mid-cycle with a valid operation in stage 2 -> all outputs read 0 before the next clk edge.
REQ-039 SHALL cover: 300 consecutive overflowing operations with the macro defined -> ovf_count=255 and held; with the macro undefined -> ovf_count=0 throughout.
